seg_disp_arbiter: RTL and testbench

Shares the single 6-digit dynamic seven-segment display between three display sources, e.g. clock, counter and sensor readout. Selects one source at a time with round-robin, minimum-hold-time arbitration, and blanks the display between hand-overs. Drives the data/point/sign/seg_en inputs of the existing seg_595_dynamic display driver. All outputs are registered.

---
 rtl/seg_disp_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter
// Lets three display sources (clock, counter, sensor, ...) share one
// 6-digit dynamic seven-segment display. One source is granted at a time,
// chosen round-robin. The current owner keeps the display for a minimum
// hold time, and the display is blanked for a short gap whenever ownership
// changes hands. All outputs feed the seg_595_dynamic driver and are
// registered.

module seg_disp_arbiter #(
    parameter logic [25:0] HOLD_CNT  = 26'd49_999_999,
    parameter logic [15:0] BLANK_CNT = 16'd24_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  req,
    input  logic [59:0] data_in,
    input  logic [17:0] point_in,
    input  logic [2:0]  sign_in,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic [2:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [25:0] holdCnt_q, holdCnt_d;
    logic [15:0] blankCnt_q, blankCnt_d;
    logic [19:0] data_q, data_d;
    logic [5:0]  point_q, point_d;
    logic        sign_q, sign_d;
    logic        segEn_q, segEn_d;
    logic [2:0]  grant_q, grant_d;
    logic        busy_q, busy_d;

    logic [2:0]  ownerMask;
    logic [2:0]  otherReq;
    logic        ownerReq;
    logic        holdDone;
    logic        blankDone;
    logic [1:0]  winner;
    logic [1:0]  selIdx;
    logic [19:0] selData;
    logic [5:0]  selPoint;
    logic        selSign;

    function automatic logic [2:0] toOneHot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    // The last winner is the owner while showing; its request and the
    // remaining requests decide whether ownership must move on.
    assign ownerMask = toOneHot(last_q);
    assign ownerReq  = |(req & ownerMask);
    assign otherReq  = req & ~ownerMask;
    assign holdDone  = (holdCnt_q == HOLD_CNT);
    assign blankDone = (blankCnt_q == (BLANK_CNT - 16'd1));

    // Round-robin search starting just after the previous winner, wrapping.
    always_comb begin
        winner = 2'd0;
        case (last_q)
            2'd0: begin
                if (req[1])      winner = 2'd1;
                else if (req[2]) winner = 2'd2;
                else             winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      winner = 2'd2;
                else if (req[0]) winner = 2'd0;
                else             winner = 2'd1;
            end
            default: begin
                if (req[0])      winner = 2'd0;
                else if (req[1]) winner = 2'd1;
                else             winner = 2'd2;
            end
        endcase
    end

    // A running show keeps reading its own slice; a new grant reads the winner's.
    assign selIdx = (state_q == SHOW) ? last_q : winner;

    // Pick the data/point/sign slice of the selected source.
    always_comb begin
        selData  = data_in[19:0];
        selPoint = point_in[5:0];
        selSign  = sign_in[0];
        case (selIdx)
            2'd1: begin
                selData  = data_in[39:20];
                selPoint = point_in[11:6];
                selSign  = sign_in[1];
            end
            2'd2: begin
                selData  = data_in[59:40];
                selPoint = point_in[17:12];
                selSign  = sign_in[2];
            end
            default: begin
                selData  = data_in[19:0];
                selPoint = point_in[5:0];
                selSign  = sign_in[0];
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a dropped owner request wins over hold expiry, and
    // requests are only looked at again once the blank gap is over.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) state_d = SHOW;
            end
            SHOW: begin
                if (!ownerReq) begin
                    state_d = (|otherReq) ? BLANK : IDLE;
                end else if (holdDone && (|otherReq)) begin
                    state_d = BLANK;
                end else begin
                    state_d = SHOW;
                end
            end
            BLANK: begin
                if (blankDone) begin
                    state_d = (|req) ? SHOW : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and counter next values, driven by the state being entered;
    // both counters restart from zero on every state entry.
    always_comb begin
        last_d     = last_q;
        holdCnt_d  = 26'd0;
        blankCnt_d = 16'd0;
        data_d     = data_q;
        point_d    = point_q;
        sign_d     = sign_q;
        segEn_d    = 1'b0;
        grant_d    = 3'b000;
        busy_d     = 1'b0;
        case (state_d)
            SHOW: begin
                segEn_d  = 1'b1;
                busy_d   = 1'b1;
                data_d   = selData;
                point_d  = selPoint;
                sign_d   = selSign;
                if (state_q == SHOW) begin
                    grant_d   = grant_q;
                    holdCnt_d = holdDone ? holdCnt_q : (holdCnt_q + 26'd1);
                end else begin
                    grant_d = toOneHot(winner);
                    last_d  = winner;
                end
            end
            BLANK: begin
                busy_d = 1'b1;
                if (state_q == BLANK) begin
                    blankCnt_d = blankCnt_q + 16'd1;
                end
            end
            default: begin
                data_d  = 20'd0;
                point_d = 6'd0;
                sign_d  = 1'b0;
            end
        endcase
    end

    // Registered outputs, counters and round-robin pointer; after reset
    // the pointer sits on source 2 so source 0 is served first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q     <= 2'd2;
            holdCnt_q  <= 26'd0;
            blankCnt_q <= 16'd0;
            data_q     <= 20'd0;
            point_q    <= 6'd0;
            sign_q     <= 1'b0;
            segEn_q    <= 1'b0;
            grant_q    <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            last_q     <= last_d;
            holdCnt_q  <= holdCnt_d;
            blankCnt_q <= blankCnt_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            segEn_q    <= segEn_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign data   = data_q;
    assign point  = point_q;
    assign sign   = sign_q;
    assign seg_en = segEn_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter
// Directed bench for seg_disp_arbiter with a short hold (8) and blank (4).
// A behavioural model tracks owner, time owned and blank time left, and is
// compared against the DUT on every falling clock edge; hand-computed
// literal checks pin the model at the key moments of each scenario.

module tb_seg_disp_arbiter;

    localparam int HOLD  = 8;
    localparam int BLANK = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [59:0] data_in;
    logic [17:0] point_in;
    logic [2:0]  sign_in;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [2:0]  grant;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    // Model state: who owns the display, how long, and blank cycles left.
    int          mOwner;
    int          mLast;
    int          mAge;
    int          mBlankLeft;
    logic [19:0] mData;
    logic [5:0]  mPoint;
    logic        mSign;

    logic [2:0]  gTrace [0:47];

    seg_disp_arbiter #(
        .HOLD_CNT  (26'd8),
        .BLANK_CNT (16'd4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req       (req),
        .data_in   (data_in),
        .point_in  (point_in),
        .sign_in   (sign_in),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .grant     (grant),
        .busy      (busy)
    );

    // 100 MHz-style free-running clock for simulation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r);
        req = r;
    endtask

    task automatic setSource(input int idx, input logic [19:0] d,
                             input logic [5:0] p, input logic s);
        data_in[20*idx +: 20] = d;
        point_in[6*idx +: 6]  = p;
        sign_in[idx]          = s;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(3'b000);
        tick(2);
        rst_n = 1'b1;
    endtask

    function automatic int pickNext(input logic [2:0] r, input int lastIdx);
        int idx;
        for (int k = 1; k <= 3; k++) begin
            idx = (lastIdx + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelLoad(input int idx);
        mData  = data_in[20*idx +: 20];
        mPoint = point_in[6*idx +: 6];
        mSign  = sign_in[idx];
    endtask

    task automatic modelGrant(input int idx);
        mOwner = idx;
        mLast  = idx;
        mAge   = 0;
        modelLoad(idx);
    endtask

    task automatic modelIdle();
        mOwner     = -1;
        mBlankLeft = 0;
        mData      = '0;
        mPoint     = '0;
        mSign      = 1'b0;
    endtask

    task automatic modelReset();
        modelIdle();
        mLast = 2;
        mAge  = 0;
    endtask

    // One clock of the arbitration rules, applied to the inputs at the edge.
    task automatic modelStep();
        logic [2:0] r;
        logic       others;
        r = req;
        if (mBlankLeft > 0) begin
            mBlankLeft--;
            if (mBlankLeft == 0) begin
                if (r != 3'b000) modelGrant(pickNext(r, mLast));
                else             modelIdle();
            end
        end else if (mOwner >= 0) begin
            others = (r & ~(3'b001 << mOwner)) != 3'b000;
            if (!r[mOwner] || (mAge >= HOLD && others)) begin
                if (others) begin
                    mOwner     = -1;
                    mBlankLeft = BLANK;
                end else begin
                    modelIdle();
                end
            end else begin
                mAge++;
                modelLoad(mOwner);
            end
        end else if (r != 3'b000) begin
            modelGrant(pickNext(r, mLast));
        end
    endtask

    // Advance the model alongside the DUT, including its async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelStep();
    end

    // Compare every DUT output with the model away from the active edge.
    always @(negedge clk) begin
        checkOutput("model grant",  {29'd0, grant},  (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
        checkOutput("model seg_en", {31'd0, seg_en}, {31'd0, (mOwner >= 0)});
        checkOutput("model busy",   {31'd0, busy},   {31'd0, (mOwner >= 0) || (mBlankLeft > 0)});
        checkOutput("model data",   {12'd0, data},   {12'd0, mData});
        checkOutput("model point",  {26'd0, point},  {26'd0, mPoint});
        checkOutput("model sign",   {31'd0, sign},   {31'd0, mSign});
    end

    initial begin
        rst_n    = 1'b0;
        req      = 3'b000;
        data_in  = '0;
        point_in = '0;
        sign_in  = '0;
        setSource(0, 20'd111111, 6'b000001, 1'b0);
        setSource(1, 20'd123456, 6'b000100, 1'b0);
        setSource(2, 20'hFFFFF,  6'b100001, 1'b1);

        // Reset state.
        tick(2);
        checkOutput("reset grant",  {29'd0, grant},  32'd0);
        checkOutput("reset seg_en", {31'd0, seg_en}, 32'd0);
        checkOutput("reset busy",   {31'd0, busy},   32'd0);
        checkOutput("reset data",   {12'd0, data},   32'd0);
        checkOutput("reset point",  {26'd0, point},  32'd0);
        checkOutput("reset sign",   {31'd0, sign},   32'd0);
        rst_n = 1'b1;

        // Lone request from source 1 appears one cycle later and stays.
        applyStimulus(3'b010);
        tick(1);
        checkOutput("t1 grant",  {29'd0, grant},  32'd2);
        checkOutput("t1 seg_en", {31'd0, seg_en}, 32'd1);
        checkOutput("t1 busy",   {31'd0, busy},   32'd1);
        checkOutput("t1 data",   {12'd0, data},   32'd123456);
        checkOutput("t1 point",  {26'd0, point},  32'd4);
        tick(20);
        checkOutput("t1 still granted", {29'd0, grant}, 32'd2);
        setSource(1, 20'd654321, 6'b000100, 1'b0);
        tick(1);
        checkOutput("t1 data follows", {12'd0, data}, 32'd654321);

        // Competitor waits for hold expiry, then a 4-cycle blank.
        doReset();
        applyStimulus(3'b001);
        tick(1);
        checkOutput("t2 first grant", {29'd0, grant}, 32'd1);
        tick(2);
        applyStimulus(3'b101);
        tick(6);
        checkOutput("t2 held at hold=8", {29'd0, grant}, 32'd1);
        tick(1);
        checkOutput("t2 blank grant",  {29'd0, grant},  32'd0);
        checkOutput("t2 blank seg_en", {31'd0, seg_en}, 32'd0);
        checkOutput("t2 blank busy",   {31'd0, busy},   32'd1);
        checkOutput("t2 blank data",   {12'd0, data},   32'd111111);
        tick(3);
        checkOutput("t2 blank end", {29'd0, grant}, 32'd0);
        tick(1);
        checkOutput("t2 src2 grant", {29'd0, grant}, 32'd4);
        checkOutput("t2 src2 data",  {12'd0, data},  32'h000FFFFF);
        checkOutput("t2 src2 sign",  {31'd0, sign},  32'd1);

        // All three requesting: rotation 001, 010, 100, 001.
        doReset();
        applyStimulus(3'b111);
        tick(1);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            gTrace[i] = grant;
        end
        checkOutput("t3 g0",  {29'd0, gTrace[0]},  32'd1);
        checkOutput("t3 g8",  {29'd0, gTrace[8]},  32'd1);
        checkOutput("t3 g9",  {29'd0, gTrace[9]},  32'd0);
        checkOutput("t3 g12", {29'd0, gTrace[12]}, 32'd0);
        checkOutput("t3 g13", {29'd0, gTrace[13]}, 32'd2);
        checkOutput("t3 g21", {29'd0, gTrace[21]}, 32'd2);
        checkOutput("t3 g22", {29'd0, gTrace[22]}, 32'd0);
        checkOutput("t3 g26", {29'd0, gTrace[26]}, 32'd4);
        checkOutput("t3 g34", {29'd0, gTrace[34]}, 32'd4);
        checkOutput("t3 g35", {29'd0, gTrace[35]}, 32'd0);
        checkOutput("t3 g39", {29'd0, gTrace[39]}, 32'd1);

        // Owner drops with nobody waiting -> straight to idle.
        doReset();
        applyStimulus(3'b001);
        tick(3);
        applyStimulus(3'b000);
        tick(1);
        checkOutput("t4 idle grant",  {29'd0, grant},  32'd0);
        checkOutput("t4 idle seg_en", {31'd0, seg_en}, 32'd0);
        checkOutput("t4 idle busy",   {31'd0, busy},   32'd0);
        checkOutput("t4 idle data",   {12'd0, data},   32'd0);

        // Owner drops with a competitor waiting -> blank, then competitor.
        applyStimulus(3'b001);
        tick(1);
        checkOutput("t4 regrant", {29'd0, grant}, 32'd1);
        applyStimulus(3'b010);
        tick(1);
        checkOutput("t4 drop blank", {31'd0, busy}, 32'd1);
        tick(3);
        checkOutput("t4 still blank", {29'd0, grant}, 32'd0);
        tick(1);
        checkOutput("t4 competitor", {29'd0, grant}, 32'd2);

        // Owner drops exactly at hold expiry; competitor leaves during blank.
        doReset();
        applyStimulus(3'b011);
        tick(1);
        checkOutput("t5 grant", {29'd0, grant}, 32'd1);
        tick(8);
        applyStimulus(3'b010);
        tick(1);
        checkOutput("t5 blank grant", {29'd0, grant}, 32'd0);
        checkOutput("t5 blank busy",  {31'd0, busy},  32'd1);
        applyStimulus(3'b000);
        tick(3);
        checkOutput("t5 late blank busy", {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("t5 idle busy",  {31'd0, busy},  32'd0);
        checkOutput("t5 idle grant", {29'd0, grant}, 32'd0);

        // Reset mid-blank clears outputs without waiting for a clock.
        doReset();
        applyStimulus(3'b011);
        tick(1);
        applyStimulus(3'b010);
        tick(2);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async busy", {31'd0, busy}, 32'd0);
        checkOutput("t6 async data", {12'd0, data}, 32'd0);
        checkOutput("t6 async sign", {31'd0, sign}, 32'd0);
        applyStimulus(3'b101);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("t6 src0 first", {29'd0, grant}, 32'd1);
        checkOutput("t6 src0 data",  {12'd0, data},  32'd111111);

        tick(2);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
